// File: rtl/aes_inv_cipher_iter_if.sv
// Request/response bundle of the iterative AES decryptor.
// The abort request exists only when AES_DEC_ABORT_EN is defined.
interface aes_inv_cipher_iter_if #(
    parameter int KEY_LENGTH = 128
);
    logic                  start;
    logic [0:127]          cipher_txt;
    logic [0:KEY_LENGTH-1] key;
`ifdef AES_DEC_ABORT_EN
    logic                  abort;
`endif
    logic                  busy;
    logic                  done;
    logic [0:127]          plain_txt;

`ifdef AES_DEC_ABORT_EN
    modport master (output start, cipher_txt, key, abort, input busy, done, plain_txt);
    modport slave  (input start, cipher_txt, key, abort, output busy, done, plain_txt);
`else
    modport master (output start, cipher_txt, key, input busy, done, plain_txt);
    modport slave  (input start, cipher_txt, key, output busy, done, plain_txt);
`endif
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative FIPS-197 inverse cipher, one round per clock, AES-128/192/256.
// Optional abort request enabled by defining AES_DEC_ABORT_EN.
module aes_inv_cipher_iter #(
    parameter int KEY_LENGTH = 128
) (
    input logic                  clk,
    input logic                  rst_n,
    aes_inv_cipher_iter_if.slave io_bus
);
    localparam int NK = KEY_LENGTH / 32;
    localparam int NR = NK + 6;
    localparam int RW = $clog2(NR + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL} state_e;
    typedef logic [NR:0][127:0] rk_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte i of a block sits at [127-8i -: 8]; byte 4c+r is row r, column c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic rk_t expand_key(input logic [KEY_LENGTH-1:0] k);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_t         rk;
        rc = 8'h01;
        for (int i = 0; i < 4 * (NR + 1); i++) begin
            if (i < NK) begin
                w[i] = k[KEY_LENGTH-1-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % NK == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = xtime(rc);
                end else if (NK > 6 && i % NK == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-NK] ^ t;
            end
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    state_e                r_fsm;
    state_e                w_fsm_nxt;
    logic [127:0]          r_state;
    logic [KEY_LENGTH-1:0] r_key;
    logic [RW-1:0]         r_rnd;
    logic                  r_busy;
    logic                  r_done;
    logic [127:0]          r_plain;

    logic                  w_abort;
    logic                  w_load;
    logic                  w_round;
    logic                  w_final;
    logic                  w_clear;
    logic [KEY_LENGTH-1:0] w_key_src;
    rk_t                   w_rk;
    logic [127:0]          w_isb;
    logic [127:0]          w_ark;

`ifdef AES_DEC_ABORT_EN
    assign w_abort = io_bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // The initial AddRoundKey needs rk[Nr] of the key being accepted, so the
    // schedule looks at the port while idle and at the latched key otherwise.
    assign w_key_src = (r_fsm == S_IDLE) ? io_bus.key : r_key;
    assign w_rk      = expand_key(w_key_src);

    // In FINAL r_rnd has reached 0, so the same key select serves both phases.
    assign w_isb = inv_sub_bytes(inv_shift_rows(r_state));
    assign w_ark = w_isb ^ w_rk[r_rnd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_load    = 1'b0;
        w_round   = 1'b0;
        w_final   = 1'b0;
        w_clear   = 1'b0;
        unique case (r_fsm)
            S_IDLE: begin
                if (io_bus.start && !w_abort) begin
                    w_load    = 1'b1;
                    w_fsm_nxt = (NR == 1) ? S_FINAL : S_RUN;
                end
            end
            S_RUN: begin
                w_round = 1'b1;
                if (r_rnd == RW'(1)) w_fsm_nxt = S_FINAL;
            end
            S_FINAL: begin
                w_final   = 1'b1;
                w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
        if (w_abort && r_fsm != S_IDLE) begin
            w_fsm_nxt = S_IDLE;
            w_round   = 1'b0;
            w_final   = 1'b0;
            w_clear   = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_key   <= '0;
            r_rnd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_plain <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_state <= io_bus.cipher_txt ^ w_rk[NR];
                r_key   <= io_bus.key;
                r_rnd   <= RW'(NR - 1);
                r_busy  <= 1'b1;
            end else if (w_round) begin
                r_state <= inv_mix_columns(w_ark);
                r_rnd   <= r_rnd - RW'(1);
            end else if (w_final) begin
                r_plain <= w_ark;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
            end else if (w_clear) begin
                r_state <= '0;
                r_rnd   <= '0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.plain_txt = r_plain;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed-vector bench for aes_inv_cipher_iter with one instance per key size.
// Abort scenarios run only when AES_DEC_ABORT_EN is defined.
module tb_aes_inv_cipher_iter;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    aes_inv_cipher_iter_if #(.KEY_LENGTH(128)) if128 ();
    aes_inv_cipher_iter_if #(.KEY_LENGTH(192)) if192 ();
    aes_inv_cipher_iter_if #(.KEY_LENGTH(256)) if256 ();

    aes_inv_cipher_iter #(.KEY_LENGTH(128)) dut128 (.clk(clk), .rst_n(rst_n), .io_bus(if128.slave));
    aes_inv_cipher_iter #(.KEY_LENGTH(192)) dut192 (.clk(clk), .rst_n(rst_n), .io_bus(if192.slave));
    aes_inv_cipher_iter #(.KEY_LENGTH(256)) dut256 (.clk(clk), .rst_n(rst_n), .io_bus(if256.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY_C  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;

    // Keys are passed left-aligned; each instance takes its leading bits.
    task automatic drive(input int sel, input logic st, input logic [127:0] ct, input logic [255:0] k);
        case (sel)
            0: begin if128.start = st; if128.cipher_txt = ct; if128.key = k[255:128]; end
            1: begin if192.start = st; if192.cipher_txt = ct; if192.key = k[255:64]; end
            default: begin if256.start = st; if256.cipher_txt = ct; if256.key = k; end
        endcase
    endtask

    task automatic set_start(input int sel, input logic st);
        case (sel)
            0: if128.start = st;
            1: if192.start = st;
            default: if256.start = st;
        endcase
    endtask

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return if128.busy;
            1: return if192.busy;
            default: return if256.busy;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0: return if128.done;
            1: return if192.done;
            default: return if256.done;
        endcase
    endfunction

    function automatic logic [127:0] get_plain(input int sel);
        case (sel)
            0: return if128.plain_txt;
            1: return if192.plain_txt;
            default: return if256.plain_txt;
        endcase
    endfunction

    // Pulses start, then counts edges after the accepting edge until done.
    task automatic run_block(input int sel, input logic [255:0] k, input logic [127:0] ct,
                             output int lat, output int nbusy, output logic [127:0] pt);
        @(negedge clk);
        drive(sel, 1'b1, ct, k);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        nbusy = get_busy(sel) ? 1 : 0;
        lat   = -1;
        pt    = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (get_done(sel)) begin
                lat = i;
                pt  = get_plain(sel);
                break;
            end
            if (get_busy(sel)) nbusy++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        drive(2, 1'b0, '0, '0);
`ifdef AES_DEC_ABORT_EN
        if128.abort = 1'b0;
        if192.abort = 1'b0;
        if256.abort = 1'b0;
`endif
        #12;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (get_busy(s) !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", s, get_busy(s)); end
            checks++;
            if (get_done(s) !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b expected 0", s, get_done(s)); end
            checks++;
            if (get_plain(s) !== 128'h0) begin errors++; $display("FAIL reset_plain[%0d]: got %h expected 0", s, get_plain(s)); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (get_busy(0) !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", get_busy(0)); end
    endtask

    task automatic test_appendix_b();
        int lat, nb;
        logic [127:0] pt;
        run_block(0, KEY_B, CT_B, lat, nb, pt);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL b_latency: got %0d expected 10", lat); end
        checks++;
        if (nb !== 10) begin errors++; $display("FAIL b_busy_cycles: got %0d expected 10", nb); end
        checks++;
        if (pt !== PT_B) begin errors++; $display("FAIL b_plain: got %h expected %h", pt, PT_B); end
        @(posedge clk);
        #1;
        checks++;
        if (if128.done !== 1'b0) begin errors++; $display("FAIL b_done_pulse: got %b expected 0", if128.done); end
        checks++;
        if (if128.plain_txt !== PT_B) begin errors++; $display("FAIL b_plain_hold: got %h expected %h", if128.plain_txt, PT_B); end
    endtask

    task automatic test_key_sizes();
        logic [127:0] cts [3];
        int           lats [3];
        int lat, nb;
        logic [127:0] pt;
        cts[0] = CT_C128; cts[1] = CT_C192; cts[2] = CT_C256;
        lats[0] = 10;     lats[1] = 12;     lats[2] = 14;
        for (int s = 0; s < 3; s++) begin
            run_block(s, KEY_C, cts[s], lat, nb, pt);
            checks++;
            if (lat !== lats[s]) begin errors++; $display("FAIL c1_latency[%0d]: got %0d expected %0d", s, lat, lats[s]); end
            checks++;
            if (nb !== lats[s]) begin errors++; $display("FAIL c1_busy_cycles[%0d]: got %0d expected %0d", s, nb, lats[s]); end
            checks++;
            if (pt !== PT_C) begin errors++; $display("FAIL c1_plain[%0d]: got %h expected %h", s, pt, PT_C); end
        end
    endtask

    task automatic test_churn();
        int ndone, lat;
        logic [127:0] pt;
        ndone = 0;
        lat   = -1;
        pt    = 'x;
        @(negedge clk);
        drive(0, 1'b1, CT_C128, KEY_C);
        @(posedge clk);
        #1;
        set_start(0, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (if128.done) begin
                ndone++;
                if (ndone == 1) begin lat = i; pt = if128.plain_txt; end
            end
            if (i == 3 || i == 7)
                drive(0, 1'b1, {$urandom(), $urandom(), $urandom(), $urandom()},
                      {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0});
            else if (i == 4 || i == 8)
                set_start(0, 1'b0);
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL churn_done_count: got %0d expected 1", ndone); end
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL churn_latency: got %0d expected 10", lat); end
        checks++;
        if (pt !== PT_C) begin errors++; $display("FAIL churn_plain: got %h expected %h", pt, PT_C); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, extra;
        logic [127:0] p1, p2;
        d1 = -1; d2 = -1; extra = 0;
        p1 = 'x; p2 = 'x;
        @(negedge clk);
        drive(0, 1'b1, CT_B, KEY_B);
        @(posedge clk);
        #1;
        drive(0, 1'b1, CT_C128, KEY_C);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 11) set_start(0, 1'b0);
            if (if128.done) begin
                if (d1 < 0)      begin d1 = i; p1 = if128.plain_txt; end
                else if (d2 < 0) begin d2 = i; p2 = if128.plain_txt; end
                else extra++;
            end
        end
        checks++;
        if (d1 !== 10) begin errors++; $display("FAIL b2b_first_done: got %0d expected 10", d1); end
        checks++;
        if (d2 - d1 !== 11) begin errors++; $display("FAIL b2b_spacing: got %0d expected 11", d2 - d1); end
        checks++;
        if (p1 !== PT_B) begin errors++; $display("FAIL b2b_plain1: got %h expected %h", p1, PT_B); end
        checks++;
        if (p2 !== PT_C) begin errors++; $display("FAIL b2b_plain2: got %h expected %h", p2, PT_C); end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL b2b_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        int lat, nb;
        logic [127:0] pt;
        @(negedge clk);
        drive(0, 1'b1, CT_B, KEY_B);
        @(posedge clk);
        #1;
        set_start(0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (if128.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", if128.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if128.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", if128.busy); end
        checks++;
        if (if128.done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b expected 0", if128.done); end
        checks++;
        if (if128.plain_txt !== 128'h0) begin errors++; $display("FAIL mid_reset_plain: got %h expected 0", if128.plain_txt); end
        @(negedge clk);
        rst_n = 1'b1;
        run_block(0, KEY_B, CT_B, lat, nb, pt);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL after_reset_latency: got %0d expected 10", lat); end
        checks++;
        if (pt !== PT_B) begin errors++; $display("FAIL after_reset_plain: got %h expected %h", pt, PT_B); end
    endtask

`ifdef AES_DEC_ABORT_EN
    task automatic test_abort();
        int lat, nb, ndone;
        logic [127:0] pt;
        run_block(0, KEY_C, CT_C128, lat, nb, pt);
        checks++;
        if (pt !== PT_C) begin errors++; $display("FAIL abort_prior_plain: got %h expected %h", pt, PT_C); end
        @(negedge clk);
        drive(0, 1'b1, CT_B, KEY_B);
        @(posedge clk);
        #1;
        set_start(0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        if128.abort = 1'b1;
        @(posedge clk);
        #1;
        if128.abort = 1'b0;
        checks++;
        if (if128.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", if128.busy); end
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (if128.done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL abort_done_count: got %0d expected 0", ndone); end
        checks++;
        if (if128.plain_txt !== PT_C) begin errors++; $display("FAIL abort_plain_kept: got %h expected %h", if128.plain_txt, PT_C); end
        @(negedge clk);
        if128.start = 1'b1;
        if128.abort = 1'b1;
        @(posedge clk);
        #1;
        if128.start = 1'b0;
        if128.abort = 1'b0;
        checks++;
        if (if128.busy !== 1'b0) begin errors++; $display("FAIL abort_start_busy: got %b expected 0", if128.busy); end
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (if128.done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL abort_start_done: got %0d expected 0", ndone); end
        run_block(0, KEY_B, CT_B, lat, nb, pt);
        checks++;
        if (pt !== PT_B) begin errors++; $display("FAIL abort_recover_plain: got %h expected %h", pt, PT_B); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_appendix_b();
        test_key_sizes();
        test_churn();
        test_back_to_back();
        test_reset_mid();
`ifdef AES_DEC_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
